ram_copy_engine: RTL and testbench

Block-copy initiator for the dual-port asynchronous-read RAM. It reads a word range through RAM port A and writes it through port B, at one word per cycle. It handles overlapping source/destination ranges by choosing the copy direction. It sits between the lab control logic (start/len/address registers) and the RAM, and is the only master on both RAM ports while busy.

---
 rtl/ram_copy_engine_pkg.sv | 16 +
 rtl/ram_copy_engine.sv | 129 ++++++++++++
 tb/tb_ram_copy_engine.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_copy_engine_pkg.sv
// Shared definitions for the RAM copy engine and its RAM: FSM states and the
// default geometry, so that both sides agree on word width, address width and depth.
package ram_copy_engine_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_RAM_DEPTH  = 80;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_copy_engine.sv
// Block-copy initiator: reads a word range on RAM port A and writes it on port B at one
// word per cycle. The copy runs descending when the destination overlaps the tail of the source.
module ram_copy_engine
  import ram_copy_engine_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RAM_DEPTH  = DEF_RAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cs,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic                  oe_a,
  output logic                  we_a,
  output logic [DATA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0] dout_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] din_b,
  output logic                  we_b,
  output logic                  oe_b,
  input  logic [DATA_WIDTH-1:0] dout_b
);

  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(RAM_DEPTH);

  state_t state_q, state_d;

  logic [ADDR_WIDTH:0]   src_end, dst_end;
  logic                  start_ok, start_desc;
  logic [ADDR_WIDTH-1:0] first_src, first_dst;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, remain_q;
  logic                  desc_q;
  logic                  unused_dout_b;

  function automatic logic [ADDR_WIDTH-1:0] step(input logic [ADDR_WIDTH-1:0] p,
                                                 input logic dn);
    return dn ? p - ADDR_WIDTH'(1) : p + ADDR_WIDTH'(1);
  endfunction

  // Range ends carry one extra bit so that src/dst near the top of the address space cannot wrap.
  assign src_end    = {1'b0, src_addr} + {1'b0, len};
  assign dst_end    = {1'b0, dst_addr} + {1'b0, len};
  assign start_ok   = (len != '0) && (src_end <= DEPTH_X) && (dst_end <= DEPTH_X);
  assign start_desc = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);
  assign first_src  = start_desc ? src_addr + len - ADDR_WIDTH'(1) : src_addr;
  assign first_dst  = start_desc ? dst_addr + len - ADDR_WIDTH'(1) : dst_addr;

  assign cs            = busy;
  assign we_a          = 1'b0;
  assign din_a         = '0;
  assign oe_b          = 1'b0;
  assign unused_dout_b = ^dout_b;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && start_ok) state_d = S_READ;
      S_READ:  if (remain_q == ADDR_WIDTH'(1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Port B trails port A by one cycle: the word read in this cycle is written next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      addr_a   <= '0;
      oe_a     <= 1'b0;
      addr_b   <= '0;
      din_b    <= '0;
      we_b     <= 1'b0;
      wr_ptr_q <= '0;
      remain_q <= '0;
      desc_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              busy     <= 1'b1;
              oe_a     <= 1'b1;
              addr_a   <= first_src;
              wr_ptr_q <= first_dst;
              remain_q <= len;
              desc_q   <= start_desc;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_READ: begin
          din_b    <= dout_a;
          addr_b   <= wr_ptr_q;
          we_b     <= 1'b1;
          wr_ptr_q <= step(wr_ptr_q, desc_q);
          remain_q <= remain_q - ADDR_WIDTH'(1);
          if (remain_q == ADDR_WIDTH'(1)) oe_a   <= 1'b0;
          else                            addr_a <= step(addr_a, desc_q);
        end
        S_DRAIN: begin
          we_b <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: table vectors, hand sequences and random copies checked
// against a memmove-style reference model over a behavioural async-read RAM.
module tb_ram_copy_engine;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 80;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0, len = '0;
  logic          busy, done, err, cs, oe_a, we_a, we_b, oe_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, dout_a, din_b, dout_b;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] pl_mem  [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic          pl_go = 1'b0;

  int n_vec = 0, n_err = 0, static_viol = 0;

  typedef struct {
    int src; int dst; int len; int mul;
    bit rej; int rd0; int wr0;
  } vec_t;
  vec_t tbl [12];

  ram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .err(err), .cs(cs),
    .addr_a(addr_a), .oe_a(oe_a), .we_a(we_a), .din_a(din_a), .dout_a(dout_a),
    .addr_b(addr_b), .din_b(din_b), .we_b(we_b), .oe_b(oe_b), .dout_b(dout_b)
  );

  always #5 clk = ~clk;

  assign dout_a = (oe_a && addr_a < AW'(DEPTH)) ? ram[addr_a[6:0]] : '0;
  assign dout_b = '0;

  always @(posedge clk) begin
    if (pl_go) begin
      for (int i = 0; i < DEPTH; i++) ram[i] = pl_mem[i];
    end else if (we_b && addr_b < AW'(DEPTH)) begin
      ram[addr_b[6:0]] = din_b;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (we_a !== 1'b0 || oe_b !== 1'b0 || din_a !== '0 || cs !== busy) static_viol++;
      if ((oe_a && addr_a >= AW'(DEPTH)) || (we_b && addr_b >= AW'(DEPTH))) static_viol++;
      if (oe_a && we_b && addr_a == addr_b) static_viol++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit m_rej(input int s, input int d, input int l);
    return (l == 0) || (s + l > DEPTH) || (d + l > DEPTH);
  endfunction

  function automatic bit m_desc(input int s, input int d, input int l);
    return (d > s) && (d < s + l);
  endfunction

  task automatic commit_ram();
    pl_go = 1'b1;
    @(posedge clk);
    #1 pl_go = 1'b0;
    @(negedge clk);
  endtask

  task automatic randomize_ram();
    for (int i = 0; i < DEPTH; i++) pl_mem[i] = DW'($urandom);
    commit_ram();
  endtask

  task automatic check_reset(input string name);
    check({name, ".flags"}, int'({busy, cs, done, err, oe_a, we_b, we_a, oe_b}), 0);
    check({name, ".addr_a"}, int'(addr_a), 0);
    check({name, ".addr_b"}, int'(addr_b), 0);
    check({name, ".din_b"}, int'(din_b), 0);
  endtask

  task automatic verify_copy(input string name, input int s, input int d, input int l,
                             input bit pulse, input bit rej, input int rd0, input int wr0);
    logic [DW-1:0] tmp [DEPTH];
    int done_cnt = 0, err_cnt = 0, busy_cnt = 0, strobe_cnt = 0;
    int done_at = -1, err_at = -1, first_rd = -1, first_wr = -1, mism = 0;
    int window = ((l > DEPTH) ? DEPTH : l) + 6;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = ram[i];
    if (!rej) begin
      for (int i = 0; i < l; i++) tmp[i] = exp_mem[s + i];
      for (int i = 0; i < l; i++) exp_mem[d + i] = tmp[i];
    end
    @(negedge clk);
    src_addr = AW'(s); dst_addr = AW'(d); len = AW'(l); start = 1'b1;
    for (int cyc = 1; cyc <= window; cyc++) begin
      @(negedge clk);
      start = pulse && (cyc == 2 || cyc == 4 || cyc == 6 || cyc == l + 2);
      if (pulse) begin src_addr = 16'd40; dst_addr = 16'd60; len = 16'd3; end
      if (busy) busy_cnt++;
      if (oe_a || we_b) strobe_cnt++;
      if (oe_a && first_rd < 0) first_rd = int'(addr_a);
      if (we_b && first_wr < 0) first_wr = int'(addr_b);
      if (done) begin done_cnt++; if (done_at < 0) done_at = cyc - 1; end
      if (err) begin err_cnt++; if (err_at < 0) err_at = cyc; end
    end
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_mem[i]) mism++;
    check({name, ".mem"}, mism, 0);
    check({name, ".done_cnt"}, done_cnt, rej ? 0 : 1);
    if (rej) begin
      check({name, ".err_cnt"}, err_cnt, 1);
      check({name, ".err_at"}, err_at, 1);
      check({name, ".busy_cnt"}, busy_cnt, 0);
      check({name, ".strobes"}, strobe_cnt, 0);
    end else begin
      check({name, ".err_cnt"}, err_cnt, 0);
      check({name, ".done_at"}, done_at, l + 1);
      check({name, ".busy_cnt"}, busy_cnt, l + 1);
      check({name, ".first_rd"}, first_rd, rd0);
      check({name, ".first_wr"}, first_wr, wr0);
    end
  endtask

  task automatic model_copy(input string name, input int s, input int d, input int l,
                            input bit pulse);
    bit dn = m_desc(s, d, l);
    verify_copy(name, s, d, l, pulse, m_rej(s, d, l),
                dn ? s + l - 1 : s, dn ? d + l - 1 : d);
  endtask

  initial begin
    int s, d, l, quiet;

    tbl[0]  = '{0, 10, 4, 11, 1'b0, 0, 10};
    tbl[1]  = '{0, 2, 5, 1, 1'b0, 4, 6};
    tbl[2]  = '{2, 0, 5, 1, 1'b0, 2, 0};
    tbl[3]  = '{5, 5, 0, 0, 1'b1, 0, 0};
    tbl[4]  = '{78, 0, 3, 0, 1'b1, 0, 0};
    tbl[5]  = '{0, 79, 2, 0, 1'b1, 0, 0};
    tbl[6]  = '{77, 0, 3, 7, 1'b0, 77, 0};
    tbl[7]  = '{0, 0, 80, 0, 1'b0, 0, 0};
    tbl[8]  = '{0, 1, 79, 0, 1'b0, 78, 79};
    tbl[9]  = '{65535, 0, 2, 0, 1'b1, 0, 0};
    tbl[10] = '{79, 79, 1, 0, 1'b0, 79, 79};
    tbl[11] = '{3, 60, 65535, 0, 1'b1, 0, 0};

    #1 rst = 1'b1;
    #1 check_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    randomize_ram();

    for (int v = 0; v < 12; v++) begin
      if (tbl[v].mul != 0) begin
        for (int i = 0; i < DEPTH; i++) pl_mem[i] = ram[i];
        for (int i = 0; i < tbl[v].len; i++) pl_mem[tbl[v].src + i] = DW'(tbl[v].mul * (i + 1));
        commit_ram();
      end
      verify_copy($sformatf("tbl%0d", v), tbl[v].src, tbl[v].dst, tbl[v].len, 1'b0,
                  tbl[v].rej, tbl[v].rd0, tbl[v].wr0);
    end

    // start pulses while busy and in the DONE cycle must be ignored
    randomize_ram();
    model_copy("busy_start", 30, 50, 6, 1'b1);

    // reset two cycles after the accept of a len=8 copy
    randomize_ram();
    src_addr = 16'd20; dst_addr = 16'd40; len = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid.busy_before", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || err || busy || oe_a || we_b) quiet++;
    end
    check("rst_mid.quiet", quiet, 0);
    model_copy("after_rst", 20, 40, 8, 1'b0);

    for (int r = 0; r < 30; r++) begin
      if (r % 5 == 0) randomize_ram();
      l = int'($urandom_range(1, 12));
      s = int'($urandom_range(0, DEPTH - 1));
      case ($urandom_range(0, 3))
        0: d = int'($urandom_range(0, DEPTH - 1));
        1: d = s + int'($urandom_range(0, l));
        2: d = s - int'($urandom_range(0, l));
        default: begin
          l = int'($urandom_range(0, 20));
          s = int'($urandom_range(DEPTH - 20, DEPTH - 1));
          d = int'($urandom_range(0, DEPTH - 1));
        end
      endcase
      if (d < 0) d = 0;
      if (d >= DEPTH) d = DEPTH - 1;
      model_copy($sformatf("rnd%0d", r), s, d, l, 1'b0);
    end

    check("static_ports", static_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
